// File: rtl/pdua_mem_arbiter.sv
// Two-requester arbiter for the PDUA data memory port: fixed CPU priority with
// a starvation counter that forces a DMA slot; each access runs IDLE -> ACC -> RESP.
module pdua_mem_arbiter #(
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wr_rdn,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_wr_rdn,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RESP
    } state_t;

    state_t        state, state_nx;
    logic          wr_q;
    logic [CW-1:0] starve_cnt;
    logic          grant_cpu, grant_dma;

    always_comb begin
        grant_dma = 1'b0;
        grant_cpu = 1'b0;
        state_nx  = state;
        case (state)
            IDLE: begin
                grant_dma = dma_req && (!cpu_req || starve_cnt == CW'(STARVE_LIMIT));
                grant_cpu = cpu_req && !grant_dma;
                if (grant_dma || grant_cpu)
                    state_nx = ACC;
            end
            ACC:     state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wr_q       <= 1'b0;
            owner      <= 1'b0;
            starve_cnt <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            if (grant_dma || grant_cpu) begin
                mem_addr  <= grant_dma ? dma_addr   : cpu_addr;
                mem_wdata <= grant_dma ? dma_wdata  : cpu_wdata;
                wr_q      <= grant_dma ? dma_wr_rdn : cpu_wr_rdn;
                owner     <= grant_dma;
                // Count only CPU wins that actually made a waiting DMA wait longer.
                if (grant_cpu && dma_req) begin
                    if (starve_cnt != CW'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + 1'b1;
                end else begin
                    starve_cnt <= '0;
                end
            end
            if (state == ACC && !wr_q) begin
                if (owner)
                    dma_rdata <= mem_rdata;
                else
                    cpu_rdata <= mem_rdata;
            end
        end
    end

    // Decoded from the state register so a reset clears them without waiting for a clock.
    assign mem_we  = (state == ACC) && wr_q;
    assign busy    = (state != IDLE);
    assign cpu_ack = (state == RESP) && !owner;
    assign dma_ack = (state == RESP) && owner;

endmodule

// File: doc/pdua_mem_arbiter.md
Name: pdua_mem_arbiter

Overview:
- Shares the single PDUA data memory port between two requesters: the CPU MAR/MDR path and a DMA/boot-loader engine.
- Sits between the control-unit-driven memory interface and the synchronous RAM.
- The CPU has fixed priority. A starvation counter guarantees the DMA a slot after a bounded number of consecutive CPU grants.
- Each access takes a fixed 3-state sequence with a one-cycle acknowledge pulse back to the winner.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- STARVE_LIMIT, 3, consecutive CPU grants allowed while dma_req is pending before the DMA is forced in (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_wr_rdn  in  1  1=write, 0=read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data, registered.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req  in  1  DMA request, held until dma_ack.
- dma_wr_rdn  in  1  1=write, 0=read.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_rdata  out  DW  DMA read data, registered.
- dma_ack  out  1  one-cycle completion pulse.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DW  RAM read data, valid the cycle after the address is presented.
- owner  out  1  0=CPU, 1=DMA; the winner of the current or last grant.
- busy  out  1  high in ACC and RESP.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, starve_cnt=0.
  - All outputs 0: mem_addr, mem_wdata, mem_we, cpu/dma_rdata, acks, owner, busy.
- States: IDLE, ACC, RESP.
- IDLE: arbitration is sampled at the rising edge.
  - No request: stay in IDLE.
  - Winner selection:
    - dma_req && (!cpu_req || starve_cnt==STARVE_LIMIT) → DMA.
    - else cpu_req → CPU.
  - On a grant: register the winner's addr, wdata and wr_rdn into mem_addr/mem_wdata; set owner; go to ACC.
- ACC (1 cycle):
  - mem_we = registered wr_rdn. mem_we is high for exactly this one cycle and is never high outside ACC.
  - mem_addr/mem_wdata are held stable.
  - Next state is RESP.
- RESP (1 cycle):
  - The winner's ack = 1.
  - For a read, the winner's rdata register captures mem_rdata at the ACC→RESP edge; rdata is valid while ack is high.
  - For a write, rdata is unchanged.
  - The loser's rdata is never modified.
  - Next state is always IDLE; there are no back-to-back grants from RESP.
- Latency: req high at edge N (state IDLE) → ACC in cycle N+1 → ack in cycle N+2. Throughput is one access per 3 cycles.
- Request rules:
  - Requesters hold req and fields stable until they see ack, then deassert req at the next edge.
  - A req still high in the IDLE following RESP is treated as a new request.
  - Field changes while req is high and before the grant are tolerated. Only the values at the granting edge are used.
- Starvation counter (updated at the IDLE grant edge):
  - CPU granted while dma_req=1 → starve_cnt+1, saturating at STARVE_LIMIT.
  - DMA granted → starve_cnt=0.
  - CPU granted while dma_req=0 → starve_cnt=0.
- Simultaneous requests: the CPU wins unless starve_cnt==STARVE_LIMIT.
- owner holds its value in IDLE. busy=1 exactly in ACC and RESP.
- Reset mid-access:
  - The access is aborted immediately: mem_we drops asynchronously and no ack is issued.
  - An interrupted write may or may not have reached the RAM.
- Addresses pass through unmodified. There is no wrap or range check; full AW-bit space.

Test Plan:
- CPU read alone: RAM[0x10]=0xA5; cpu_req=1, addr=0x10, wr_rdn=0 → mem_addr=0x10 in ACC, cpu_ack pulse at cycle N+2 with cpu_rdata=0xA5, dma_ack=0, owner=0.
- DMA write alone: dma_addr=0x20, wdata=0x3C, wr_rdn=1 → mem_we high exactly 1 cycle with mem_addr=0x20/mem_wdata=0x3C; dma_ack one pulse; readback via CPU returns 0x3C; dma_rdata unchanged.
- Simultaneous first request, starve_cnt=0 → CPU granted first (owner=0), DMA on the next IDLE grant; the two acks are 3 cycles apart.
- Starvation, STARVE_LIMIT=3: cpu_req and dma_req held continuously (CPU re-requests immediately after each ack) → grant order C,C,C,D,C,C,C,D; starve_cnt returns to 0 after each D.
- Reset mid-op: deassert rst during ACC of a write → mem_we=0 in the same cycle, no ack, state IDLE, all outputs 0; after release, pending cpu_req completes normally with ack at N+2.
- No requests for 10 cycles → mem_we=0, busy=0, both acks 0, state stays IDLE.
